// File: rtl/cdc_bus_settle_if.sv
`default_nettype none
// ============================================================================
// Module      : cdc_bus_settle_if
// Description : Bus bundle between a settled-bus consumer and the
//               cdc_bus_settle stage.
//               Signals:
//                 bus_in      - synchronized bus from the CDC array
//                 glitch_clr  - synchronous clear of glitch_cnt
//                 bus_out     - committed, settled bus value
//                 bus_update  - one-cycle strobe per committed value
//                 settling    - high while a candidate is being qualified
//                 glitch_cnt  - saturating count of rejected transients
//               Modports: master (drives bus_in/glitch_clr), slave (the
//               settle stage).
// Revision    : 1.0 - initial release
// ============================================================================
interface cdc_bus_settle_if #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned GLITCH_W = 8
);
    logic [WIDTH-1:0]    bus_in;
    logic                glitch_clr;
    logic [WIDTH-1:0]    bus_out;
    logic                bus_update;
    logic                settling;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output bus_in,
        output glitch_clr,
        input  bus_out,
        input  bus_update,
        input  settling,
        input  glitch_cnt
    );

    modport slave (
        input  bus_in,
        input  glitch_clr,
        output bus_out,
        output bus_update,
        output settling,
        output glitch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cdc_bus_settle.sv
`default_nettype none
// ============================================================================
// Module      : cdc_bus_settle
// Description : Destination-domain settle filter for a per-bit synchronized
//               bus. A new bus value is republished on bus_out only after it
//               has been sampled identically for SETTLE_CYCLES consecutive
//               edges, so skewed per-bit arrivals never reach downstream
//               logic. Rejected transients are counted in a saturating
//               counter.
//               Ports:
//                 dest_clk - destination-domain clock
//                 dest_rst - synchronous active-high reset
//                 bus      - cdc_bus_settle_if.slave (bus_in, glitch_clr,
//                            bus_out, bus_update, settling, glitch_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_bus_settle #(
    parameter int unsigned     WIDTH         = 1,
    parameter int unsigned     SETTLE_CYCLES = 2,
    parameter int unsigned     GLITCH_W      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  wire logic          dest_clk,
    input  wire logic          dest_rst,
    cdc_bus_settle_if.slave    bus
);

    // Counter only needs to reach SETTLE_CYCLES-1.
    localparam int unsigned       c_CNT_W      = $clog2(SETTLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [GLITCH_W-1:0] c_GLITCH_MAX = '1;

    generate
        if (SETTLE_CYCLES < 2) begin : g_bad_settle_cycles
            $error("cdc_bus_settle: SETTLE_CYCLES must be >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    state_t              state_q,      state_d;
    logic [WIDTH-1:0]    cand_q,       cand_d;
    logic [c_CNT_W-1:0]  cnt_q,        cnt_d;
    logic [WIDTH-1:0]    bus_out_q,    bus_out_d;
    logic                update_q,     update_d;
    logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;
    logic                glitch_ev;

    // Next-state / datapath
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        bus_out_d = bus_out_q;
        update_d  = 1'b0;
        glitch_ev = 1'b0;

        case (state_q)
            ST_STABLE: begin
                if (bus.bus_in != bus_out_q) begin
                    cand_d  = bus.bus_in;
                    cnt_d   = c_CNT_ONE;
                    state_d = ST_SETTLING;
                end
            end
            ST_SETTLING: begin
                if (bus.bus_in == bus_out_q) begin
                    // Bus fell back to the committed value: drop candidate.
                    state_d   = ST_STABLE;
                    cnt_d     = '0;
                    glitch_ev = 1'b1;
                end else if (bus.bus_in != cand_q) begin
                    // Another value arrived: restart with no carried credit.
                    cand_d    = bus.bus_in;
                    cnt_d     = c_CNT_ONE;
                    glitch_ev = 1'b1;
                end else if (cnt_q == c_CNT_LAST) begin
                    bus_out_d = cand_q;
                    update_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase

        // Clear wins over a same-cycle glitch event.
        if (bus.glitch_clr) begin
            glitch_cnt_d = '0;
        end else if (glitch_ev && (glitch_cnt_q != c_GLITCH_MAX)) begin
            glitch_cnt_d = glitch_cnt_q + GLITCH_W'(1);
        end else begin
            glitch_cnt_d = glitch_cnt_q;
        end
    end

    // State register
    always_ff @(posedge dest_clk) begin
        if (dest_rst) begin
            state_q      <= ST_STABLE;
            cand_q       <= RESET_VAL;
            cnt_q        <= '0;
            bus_out_q    <= RESET_VAL;
            update_q     <= 1'b0;
            glitch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            bus_out_q    <= bus_out_d;
            update_q     <= update_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    // All outputs come straight from registers.
    assign bus.bus_out    = bus_out_q;
    assign bus.bus_update = update_q;
    assign bus.settling   = (state_q == ST_SETTLING);
    assign bus.glitch_cnt = glitch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cdc_bus_settle.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_bus_settle
// Description : Self-checking bench for cdc_bus_settle (WIDTH=4,
//               SETTLE_CYCLES=3, GLITCH_W=2, RESET_VAL=0). Expected commits
//               (value and edge number) are queued by the stimulus; a
//               negedge monitor pops one entry per bus_update pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_bus_settle;

    localparam int unsigned c_SETTLE = 3;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        logic [3:0] val;
        int         at_edge;
    } exp_t;

    exp_t exp_q[$];

    cdc_bus_settle_if #(.WIDTH(4), .GLITCH_W(2)) bus_if ();

    cdc_bus_settle #(
        .WIDTH         (4),
        .SETTLE_CYCLES (c_SETTLE),
        .GLITCH_W      (2),
        .RESET_VAL     (4'h0)
    ) u_dut (
        .dest_clk (clk),
        .dest_rst (rst),
        .bus      (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of rising edges seen.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, cyc);
        end
    endtask

    // Value driven now is first sampled at edge cyc+1 and commits
    // SETTLE-1 edges later; extra_delay covers a preceding transient.
    task automatic expect_commit(input logic [3:0] v, input int extra_delay);
        exp_t e;
        e.val     = v;
        e.at_edge = cyc + c_SETTLE + extra_delay;
        exp_q.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus_if.bus_update === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_update: got bus_out=%0h expected no pulse (edge %0d)",
                         bus_if.bus_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_value", 32'(bus_if.bus_out), 32'(e.val));
                chk("commit_edge", 32'(cyc), 32'(e.at_edge));
            end
        end
    end

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus_if.bus_in    = 4'hF;
        bus_if.glitch_clr = 1'b0;

        // Reset held for two edges with bus_in = F
        wait_n(2);
        chk("rst_bus_out",    32'(bus_if.bus_out),    32'h0);
        chk("rst_bus_update", 32'(bus_if.bus_update), 32'h0);
        chk("rst_settling",   32'(bus_if.settling),   32'h0);
        chk("rst_glitch_cnt", 32'(bus_if.glitch_cnt), 32'h0);

        rst = 1'b0;
        expect_commit(4'hF, 0);
        wait_n(1);
        chk("post_rst_settling", 32'(bus_if.settling), 32'h1);
        chk("post_rst_bus_out_hold", 32'(bus_if.bus_out), 32'h0);
        wait_n(3);
        chk("post_rst_bus_out", 32'(bus_if.bus_out),    32'hF);
        chk("post_rst_glitch",  32'(bus_if.glitch_cnt), 32'h0);

        // Return to 0, then clean change to 5
        bus_if.bus_in = 4'h0;
        expect_commit(4'h0, 0);
        wait_n(4);
        chk("back_to_zero", 32'(bus_if.bus_out), 32'h0);

        bus_if.bus_in = 4'h5;
        expect_commit(4'h5, 0);
        wait_n(2);
        chk("clean_not_yet", 32'(bus_if.bus_out), 32'h0);
        wait_n(4);
        chk("clean_bus_out", 32'(bus_if.bus_out),    32'h5);
        chk("clean_glitch",  32'(bus_if.glitch_cnt), 32'h0);

        // Skewed arrival: 4 for one cycle, then 6
        bus_if.bus_in = 4'h4;
        expect_commit(4'h6, 1);
        wait_n(1);
        bus_if.bus_in = 4'h6;
        wait_n(5);
        chk("skew_bus_out", 32'(bus_if.bus_out),    32'h6);
        chk("skew_glitch",  32'(bus_if.glitch_cnt), 32'h1);

        // Revert: 7 for one cycle, back to 6
        bus_if.bus_in = 4'h7;
        wait_n(1);
        chk("revert_settling_hi", 32'(bus_if.settling), 32'h1);
        bus_if.bus_in = 4'h6;
        wait_n(1);
        chk("revert_settling_lo", 32'(bus_if.settling),   32'h0);
        chk("revert_glitch",      32'(bus_if.glitch_cnt), 32'h2);
        wait_n(3);
        chk("revert_bus_out", 32'(bus_if.bus_out), 32'h6);

        // Five single-cycle transients: saturate at 3
        for (int i = 0; i < 5; i++) begin
            bus_if.bus_in = 4'hA;
            wait_n(1);
            bus_if.bus_in = 4'h6;
            wait_n(1);
            if (i == 0) chk("sat_first", 32'(bus_if.glitch_cnt), 32'h3);
        end
        chk("sat_glitch", 32'(bus_if.glitch_cnt), 32'h3);

        // Sixth transient with clear on the same edge as the glitch event
        bus_if.bus_in = 4'hA;
        wait_n(1);
        bus_if.bus_in     = 4'h6;
        bus_if.glitch_clr = 1'b1;
        wait_n(1);
        bus_if.glitch_clr = 1'b0;
        chk("clr_priority", 32'(bus_if.glitch_cnt), 32'h0);
        chk("clr_bus_out",  32'(bus_if.bus_out),    32'h6);

        // Reset in the middle of qualifying 9
        bus_if.bus_in = 4'h9;
        wait_n(1);
        chk("midrst_settling_hi", 32'(bus_if.settling), 32'h1);
        rst = 1'b1;
        wait_n(1);
        chk("midrst_bus_out",  32'(bus_if.bus_out),  32'h0);
        chk("midrst_settling", 32'(bus_if.settling), 32'h0);
        chk("midrst_update",   32'(bus_if.bus_update), 32'h0);
        rst = 1'b0;
        expect_commit(4'h9, 0);
        wait_n(2);
        chk("midrst_not_yet", 32'(bus_if.bus_out), 32'h0);
        wait_n(3);
        chk("midrst_commit", 32'(bus_if.bus_out),    32'h9);
        chk("midrst_glitch", 32'(bus_if.glitch_cnt), 32'h0);

        wait_n(3);
        chk("pending_commits", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
